// File: rtl/spmv_result_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spmv_result_writer_if
//  Description : Valid/ready write-beat bus from the SpMV result writer to
//                result memory (address + one fp16 data word per beat).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spmv_result_writer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );
endinterface
`default_nettype wire

// File: rtl/spmv_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : spmv_result_writer
//  Description : Detects SpMV core completion (WRITE -> IDLE), snapshots the
//                core result bus and streams the rows to result memory one
//                word per valid/ready beat, so the core can restart at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module spmv_result_writer #(
   parameter int NUM_ROWS = 16,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8
) (
   input  wire logic                       i_clk,
   input  wire logic                       i_rstn,
   input  wire logic [2:0]                 i_core_state,
   input  wire logic [NUM_ROWS*DATA_W-1:0] i_register,
   input  wire logic [ADDR_W-1:0]          i_base_addr,
   input  wire logic                       i_clr_ovf,
   spmv_result_writer_if.master            wr,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_overflow
);

   localparam int          c_IDX_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [2:0]  c_CORE_IDLE  = 3'b000;
   localparam logic [2:0]  c_CORE_WRITE = 3'b100;
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [2:0]                   r_prev_state;
   logic [NUM_ROWS*DATA_W-1:0]   r_snap;
   logic [ADDR_W-1:0]            r_base;
   logic [c_IDX_W-1:0]           r_idx;
   logic                         r_overflow;
   logic                         w_fin;
   logic                         w_accept;

   // Completion is the core leaving WRITE straight into IDLE.
   assign w_fin = (r_prev_state == c_CORE_WRITE) && (i_core_state == c_CORE_IDLE);

   // State register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and output decode; addr/data are forced to 0 outside SEND.
   always_comb begin
      w_state_nxt = r_state;
      wr.wr_valid = 1'b0;
      wr.wr_addr  = '0;
      wr.wr_data  = '0;
      o_done      = 1'b0;
      o_busy      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fin) begin
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            o_busy      = 1'b1;
            wr.wr_valid = 1'b1;
            wr.wr_addr  = r_base + ADDR_W'(r_idx);
            wr.wr_data  = r_snap[r_idx*DATA_W +: DATA_W];
            w_accept    = wr.wr_ready;
            if (wr.wr_ready && (r_idx == c_LAST_IDX)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            o_busy      = 1'b1;
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Core state history used for edge detection of completion.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_prev_state <= 3'b000;
      end else begin
         r_prev_state <= i_core_state;
      end
   end

   // Snapshot capture on an idle completion; row index advances per accepted beat.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_snap <= '0;
         r_base <= '0;
         r_idx  <= '0;
      end else if ((r_state == S_IDLE) && w_fin) begin
         r_snap <= i_register;
         r_base <= i_base_addr;
         r_idx  <= '0;
      end else if (w_accept && (r_idx != c_LAST_IDX)) begin
         r_idx  <= r_idx + c_IDX_W'(1);
      end
   end

   // Sticky overflow: a completion while busy is dropped and flagged; set beats clear.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_overflow <= 1'b0;
      end else if (w_fin && (r_state != S_IDLE)) begin
         r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_spmv_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spmv_result_writer
//  Description : Scoreboard bench for spmv_result_writer. Stimulus pushes the
//                expected (addr, data) beats; a monitor compares every
//                presented beat against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spmv_result_writer;

   localparam int NUM_ROWS = 16;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic                       clk;
   logic                       rstn;
   logic [2:0]                 core_state;
   logic [NUM_ROWS*DATA_W-1:0] register_bus;
   logic [ADDR_W-1:0]          base_addr;
   logic                       clr_ovf;
   logic                       busy;
   logic                       done;
   logic                       overflow;

   int    n_cmp;
   int    n_err;
   int    beats;
   int    ready_mode;
   beat_t q[$];

   spmv_result_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr ();

   spmv_result_writer #(
      .NUM_ROWS (NUM_ROWS),
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_core_state (core_state),
      .i_register   (register_bus),
      .i_base_addr  (base_addr),
      .i_clr_ovf    (clr_ovf),
      .wr           (wr),
      .o_busy       (busy),
      .o_done       (done),
      .o_overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_ROWS*DATA_W-1:0] mk(input logic [DATA_W-1:0] start,
                                                     input logic [DATA_W-1:0] step);
      logic [NUM_ROWS*DATA_W-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_ROWS; k++) begin
         r[k*DATA_W +: DATA_W] = start + DATA_W'(k) * step;
      end
      return r;
   endfunction

   // Expected stream: row k at base+k (8-bit wrap), data copied bit-exact.
   task automatic push_expected(input logic [NUM_ROWS*DATA_W-1:0] r, input logic [ADDR_W-1:0] b);
      beat_t e;
      for (int k = 0; k < NUM_ROWS; k++) begin
         e.addr = b + ADDR_W'(k);
         e.data = r[k*DATA_W +: DATA_W];
         q.push_back(e);
      end
   endtask

   // Core passes WRITE -> IDLE; returns during the completion cycle C.
   task automatic issue(input logic [NUM_ROWS*DATA_W-1:0] r, input logic [ADDR_W-1:0] b,
                        input bit expect_capture);
      @(posedge clk); #1;
      core_state   = 3'b100;
      register_bus = r;
      base_addr    = b;
      @(posedge clk); #1;
      core_state   = 3'b000;
      if (expect_capture) push_expected(r, b);
   endtask

   task automatic drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #2;
         if (q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   // Ready driver: 0 = always high, 1 = repeating 1,0,0,1, 2 = always low.
   initial begin
      logic [3:0] pat;
      int         cyc;
      pat = 4'b1001;
      cyc = 0;
      wr.wr_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       wr.wr_ready = 1'b1;
            1:       wr.wr_ready = pat[cyc % 4];
            default: wr.wr_ready = 1'b0;
         endcase
         cyc++;
      end
   end

   // Monitor: every presented beat must match the queue head; pop on acceptance.
   initial begin
      forever begin
         @(negedge clk);
         if (rstn && wr.wr_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got addr %h data %h, required no beat at %0t",
                        wr.wr_addr, wr.wr_data, $time);
            end else begin
               chk("beat_addr", 32'(wr.wr_addr), 32'(q[0].addr));
               chk("beat_data", 32'(wr.wr_data), 32'(q[0].data));
               if (wr.wr_ready) begin
                  void'(q.pop_front());
                  beats++;
               end
            end
         end
      end
   end

   initial begin
      logic [NUM_ROWS*DATA_W-1:0] r;
      int                         b0;
      bit                         hit;

      n_cmp        = 0;
      n_err        = 0;
      beats        = 0;
      ready_mode   = 0;
      rstn         = 1'b0;
      core_state   = 3'b000;
      register_bus = '0;
      base_addr    = '0;
      clr_ovf      = 1'b0;

      // Reset values.
      #12;
      chk("rst_valid", 32'(wr.wr_valid), 32'd0);
      chk("rst_addr",  32'(wr.wr_addr),  32'd0);
      chk("rst_data",  32'(wr.wr_data),  32'd0);
      chk("rst_busy",  32'(busy),        32'd0);
      chk("rst_done",  32'(done),        32'd0);
      chk("rst_ovf",   32'(overflow),    32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);

      // Basic stream with exact latency; register changes after capture are ignored.
      ready_mode = 0;
      r = mk(16'h3C00, 16'h0001);
      b0 = beats;
      issue(r, 8'h20, 1'b1);
      chk("lat_C_valid", 32'(wr.wr_valid), 32'd0);
      for (int k = 1; k <= NUM_ROWS; k++) begin
         @(posedge clk); #2;
         if (k == 1) register_bus = ~r;
         chk("lat_beat_valid", 32'(wr.wr_valid), 32'd1);
         chk("lat_beat_done",  32'(done),        32'd0);
      end
      @(posedge clk); #2;
      chk("lat_done",       32'(done),        32'd1);
      chk("lat_done_valid", 32'(wr.wr_valid), 32'd0);
      chk("lat_done_busy",  32'(busy),        32'd1);
      @(posedge clk); #2;
      chk("lat_after_done", 32'(done),        32'd0);
      chk("lat_after_busy", 32'(busy),        32'd0);
      chk("basic_beats",    32'(beats - b0),  32'd16);
      chk("basic_q_empty",  32'(q.size()),    32'd0);

      // Back-pressure: ready 1,0,0,1; monitor checks held beats against queue head.
      ready_mode = 1;
      b0 = beats;
      issue(mk(16'hA000, 16'h0003), 8'h40, 1'b1);
      drain("bp_drain");
      chk("bp_beats", 32'(beats - b0), 32'd16);

      // Address wrap and bit-exact sign-zero / NaN words.
      ready_mode = 0;
      r = mk(16'h7C01, 16'h0001);
      r[3*DATA_W +: DATA_W] = 16'h8000;
      r[0 +: DATA_W]        = 16'h0000;
      b0 = beats;
      issue(r, 8'hF8, 1'b1);
      drain("wrap_drain");
      chk("wrap_beats", 32'(beats - b0), 32'd16);

      // Overflow: second completion while stalled; same-cycle clear loses to set.
      ready_mode = 2;
      chk("ovf_pre", 32'(overflow), 32'd0);
      issue(mk(16'h1111, 16'h0101), 8'h80, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      core_state   = 3'b100;
      register_bus = mk(16'hDEAD, 16'h0010);
      base_addr    = 8'hC0;
      @(posedge clk); #1;
      core_state = 3'b000;
      clr_ovf    = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      chk("ovf_set",  32'(overflow), 32'd1);
      chk("ovf_busy", 32'(busy),     32'd1);
      ready_mode = 0;
      drain("ovf_drain");
      chk("ovf_sticky", 32'(overflow), 32'd1);
      @(posedge clk); #1;
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      chk("ovf_clear", 32'(overflow), 32'd0);

      // Reset after beat 5 abandons the stream.
      ready_mode = 0;
      b0 = beats;
      issue(mk(16'h5500, 16'h0002), 8'h60, 1'b1);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (beats - b0 >= 5) begin
            hit = 1'b1;
            break;
         end
      end
      chk("mid_reach5", 32'(hit), 32'd1);
      #1;
      rstn = 1'b0;
      q.delete();
      #1;
      chk("mid_valid", 32'(wr.wr_valid), 32'd0);
      chk("mid_busy",  32'(busy),        32'd0);
      chk("mid_beats", 32'(beats - b0),  32'd5);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      chk("mid_idle_busy", 32'(busy), 32'd0);
      b0 = beats;
      issue(mk(16'h0400, 16'h0007), 8'h10, 1'b1);
      drain("mid_restart_drain");
      chk("mid_restart_beats", 32'(beats - b0), 32'd16);

      repeat (4) @(posedge clk);
      chk("final_q_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
